// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: reset vector, redirect kinds,
// fetch FSM states and the pending-redirect record.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        RK_BRANCH = 2'd0,
        RK_JUMP   = 2'd1,
        RK_JR     = 2'd2,
        RK_RSVD   = 2'd3
    } redirect_kind_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
    } pending_t;

    // Signed word offset to byte offset.
    function automatic logic [31:0] word_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target arithmetic for branch, jump and jr.
// Reserved kind falls through to pc+4; the caller ignores it anyway.
module pc_target_calc (
    input  logic [1:0]  kind,
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [25:0] index,
    input  logic [31:2] jr_word,
    output logic [31:0] target
);
    import cpu_pkg::*;

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Select target by redirect kind; all sums wrap mod 2^32.
    always_comb begin
        target = pc_plus4;
        unique case (kind)
            RK_BRANCH: target = pc_plus4 + word_offset(imm);
            RK_JUMP:   target = {pc_plus4[31:28], index, 2'b00};
            RK_JR:     target = {jr_word, 2'b00};
            default:   target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_next_gen.sv
// Fetch sequencer: drives pc_counter.next, issues imem fetches,
// applies decode redirects and hands fetched words to decode.
module pc_next_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_pc,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] next,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        misalign
);
    import cpu_pkg::*;

    fetch_state_t state, state_nx;
    pending_t     pend_q, pend_nx;

    logic [31:0] calc_target;
    logic [31:0] eff_target;
    logic [31:0] pc_plus4;
    logic        take;
    logic        have_redir;
    logic        deliver;
    logic        misalign_nx;

    pc_target_calc u_calc (
        .kind    (redirect_kind),
        .pc      (redirect_pc),
        .imm     (branch_imm),
        .index   (jump_index),
        .jr_word (jr_target[31:2]),
        .target  (calc_target)
    );

    // Reserved kind is dropped before it can touch any state.
    assign take       = redirect_valid && (redirect_kind != RK_RSVD);
    assign have_redir = take || pend_q.valid;
    // An incoming redirect is newer than anything pending.
    assign eff_target = take ? calc_target : pend_q.target;
    assign pc_plus4   = pc_current + 32'd4;
    assign imem_addr  = pc_current;

    assign misalign_nx = !reset && (state != S_IDLE) && take
                         && (redirect_kind == RK_JR)
                         && (jr_target[1:0] != 2'b00);

    // Next-state, next-PC, request and pending-redirect decisions.
    always_comb begin
        state_nx = state;
        pend_nx  = pend_q;
        imem_req = 1'b0;
        next     = pc_current;
        deliver  = 1'b0;
        if (reset) begin
            state_nx = S_IDLE;
            pend_nx  = '0;
            next     = RESET_PC;
        end else begin
            unique case (state)
                S_IDLE: begin
                    next     = RESET_PC;
                    state_nx = S_REQ;
                end
                S_REQ: begin
                    if (have_redir && !stall) begin
                        next    = eff_target;
                        pend_nx = '0;
                    end else if (stall) begin
                        if (take) pend_nx = '{valid: 1'b1, target: calc_target};
                    end else begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            next    = pc_plus4;
                            deliver = 1'b1;
                        end else begin
                            state_nx = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Request stays up until accepted; stall cannot pull it.
                    imem_req = 1'b1;
                    if (take) pend_nx = '{valid: 1'b1, target: calc_target};
                    if (imem_ready) begin
                        state_nx = S_REQ;
                        if (have_redir) begin
                            next    = eff_target;
                            pend_nx = '0;
                        end else begin
                            next    = pc_plus4;
                            deliver = 1'b1;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State, pending redirect and decode-facing output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pend_q      <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            misalign    <= 1'b0;
        end else begin
            state       <= state_nx;
            pend_q      <= pend_nx;
            instr_valid <= deliver;
            misalign    <= misalign_nx;
            if (deliver) begin
                instr_out <= imem_rdata;
                instr_pc  <= pc_current;
            end
        end
    end

endmodule

// File: tb/tb_pc_next_gen.sv
// Scoreboard bench for pc_next_gen with a pc_counter stand-in
// and a combinational instruction memory.
module tb_pc_next_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_current = 32'h0;
    logic        stall = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_kind = 2'd0;
    logic [31:0] redirect_pc = 32'h0;
    logic [15:0] branch_imm = 16'h0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] jr_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic [31:0] next;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        misalign;

    logic        pc_force_en = 1'b0;
    logic [31:0] pc_force = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pc_next_gen dut (
        .clk            (clk),
        .reset          (reset),
        .pc_current     (pc_current),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .redirect_pc    (redirect_pc),
        .branch_imm     (branch_imm),
        .jump_index     (jump_index),
        .jr_target      (jr_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .next           (next),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .misalign       (misalign)
    );

    // pc_counter stand-in, with an override to plant arbitrary PCs.
    always @(posedge clk) pc_current <= pc_force_en ? pc_force : next;

    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

    function automatic void push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.word = a ^ 32'hC0DE_0000;
        sb.push_back(e);
    endfunction

    // Scoreboard: every delivered word must match the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected got pc %h want no delivery", instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr_pc !== e.pc || instr_out !== e.word) begin
                    miscompares++;
                    $display("FAIL sb_word got %h@%h want %h@%h",
                             instr_out, instr_pc, e.word, e.pc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b1;
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3000) begin
            miscompares++;
            $display("FAIL rst_comb got req=%b next=%h want req=0 next=00003000", imem_req, next);
        end
        vectors++;
        if (instr_valid !== 1'b0 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flags got v=%b m=%b want 0 0", instr_valid, misalign);
        end
        vectors++;
        if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_regs got out=%h pc=%h want 0 0", instr_out, instr_pc);
        end
        next_cycle();
        reset = 1'b0;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3000) begin
            miscompares++;
            $display("FAIL idle_comb got req=%b next=%h want req=0 next=00003000", imem_req, next);
        end
        next_cycle();
    endtask

    task automatic test_free_run();
        do_reset();
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h3000 + 32'(4 * i);
            #2;
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== a || next !== a + 32'd4) begin
                miscompares++;
                $display("FAIL run_fetch got req=%b addr=%h next=%h want 1 %h %h",
                         imem_req, imem_addr, next, a, a + 32'd4);
            end
            if (i > 0) begin
                vectors++;
                if (instr_valid !== 1'b1 || instr_pc !== a - 32'd4) begin
                    miscompares++;
                    $display("FAIL run_trail got v=%b pc=%h want 1 %h", instr_valid, instr_pc, a - 32'd4);
                end
            end
            push_exp(a);
            next_cycle();
        end
        stall = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h300C) begin
            miscompares++;
            $display("FAIL run_stall got req=%b next=%h want 0 0000300c", imem_req, next);
        end
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL run_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_wait();
        do_reset();
        stall = 1'b0;
        imem_ready = 1'b1;
        push_exp(32'h3000);
        next_cycle();
        for (int j = 0; j < 3; j++) begin
            imem_ready = 1'b0;
            stall = (j == 1);
            #2;
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || next !== 32'h3004) begin
                miscompares++;
                $display("FAIL wait_hold got req=%b addr=%h next=%h want 1 00003004 00003004",
                         imem_req, imem_addr, next);
            end
            if (j == 2) begin
                vectors++;
                if (instr_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wait_novalid got %b want 0", instr_valid);
                end
            end
            next_cycle();
        end
        imem_ready = 1'b1;
        stall = 1'b0;
        #2;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || next !== 32'h3008) begin
            miscompares++;
            $display("FAIL wait_done got req=%b addr=%h next=%h want 1 00003004 00003008",
                     imem_req, imem_addr, next);
        end
        push_exp(32'h3004);
        next_cycle();
        stall = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3008) begin
            miscompares++;
            $display("FAIL wait_after got req=%b next=%h want 0 00003008", imem_req, next);
        end
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL wait_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_branch();
        do_reset();
        stall = 1'b0;
        imem_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_kind = 2'd0;
        redirect_pc = 32'h3010;
        branch_imm = 16'hFFFE;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h300C) begin
            miscompares++;
            $display("FAIL br_redir got req=%b next=%h want 0 0000300c", imem_req, next);
        end
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300C || next !== 32'h3010) begin
            miscompares++;
            $display("FAIL br_fetch got req=%b addr=%h next=%h want 1 0000300c 00003010",
                     imem_req, imem_addr, next);
        end
        push_exp(32'h300C);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_kind = 2'd3;
        jr_target = 32'h0000_5000;
        #2;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3010 || next !== 32'h3014) begin
            miscompares++;
            $display("FAIL br_rsvd got req=%b addr=%h next=%h want 1 00003010 00003014",
                     imem_req, imem_addr, next);
        end
        push_exp(32'h3010);
        next_cycle();
        redirect_valid = 1'b0;
        stall = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3014) begin
            miscompares++;
            $display("FAIL br_hold got req=%b next=%h want 0 00003014", imem_req, next);
        end
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL br_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_pending();
        do_reset();
        stall = 1'b0;
        imem_ready = 1'b0;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_kind = 2'd1;
        redirect_pc = 32'h3008;
        jump_index = 26'h0000C40;
        #2;
        vectors++;
        if (imem_req !== 1'b1 || next !== 32'h3000) begin
            miscompares++;
            $display("FAIL pend_wait got req=%b next=%h want 1 00003000", imem_req, next);
        end
        next_cycle();
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b1 || next !== 32'h3100) begin
            miscompares++;
            $display("FAIL pend_apply got req=%b next=%h want 1 00003100", imem_req, next);
        end
        next_cycle();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_kind = 2'd0;
        redirect_pc = 32'h3010;
        branch_imm = 16'hFFFE;
        #2;
        vectors++;
        if (instr_valid !== 1'b0 || next !== 32'h3100) begin
            miscompares++;
            $display("FAIL pend_discard got v=%b next=%h want 0 00003100", instr_valid, next);
        end
        next_cycle();
        redirect_kind = 2'd1;
        redirect_pc = 32'h3008;
        jump_index = 26'h0000C80;
        next_cycle();
        redirect_valid = 1'b0;
        stall = 1'b0;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3200) begin
            miscompares++;
            $display("FAIL pend_latest got req=%b next=%h want 0 00003200", imem_req, next);
        end
        next_cycle();
        #2;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3200 || next !== 32'h3204) begin
            miscompares++;
            $display("FAIL pend_fetch got req=%b addr=%h next=%h want 1 00003200 00003204",
                     imem_req, imem_addr, next);
        end
        push_exp(32'h3200);
        next_cycle();
        stall = 1'b1;
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pend_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_jr();
        do_reset();
        stall = 1'b0;
        imem_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_kind = 2'd2;
        jr_target = 32'h0000_3203;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3200 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL jr_redir got req=%b next=%h m=%b want 0 00003200 0",
                     imem_req, next, misalign);
        end
        next_cycle();
        redirect_valid = 1'b0;
        stall = 1'b1;
        #2;
        vectors++;
        if (misalign !== 1'b1 || next !== 32'h3200) begin
            miscompares++;
            $display("FAIL jr_pulse got m=%b next=%h want 1 00003200", misalign, next);
        end
        next_cycle();
        stall = 1'b0;
        #2;
        vectors++;
        if (misalign !== 1'b0 || imem_addr !== 32'h3200 || next !== 32'h3204) begin
            miscompares++;
            $display("FAIL jr_fetch got m=%b addr=%h next=%h want 0 00003200 00003204",
                     misalign, imem_addr, next);
        end
        push_exp(32'h3200);
        next_cycle();
        stall = 1'b1;
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL jr_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        stall = 1'b0;
        imem_ready = 1'b0;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_kind = 2'd1;
        redirect_pc = 32'h3008;
        jump_index = 26'h0000C80;
        next_cycle();
        redirect_valid = 1'b0;
        reset = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3000) begin
            miscompares++;
            $display("FAIL rw_reset got req=%b next=%h want 0 00003000", imem_req, next);
        end
        next_cycle();
        reset = 1'b0;
        imem_ready = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b0 || next !== 32'h3000 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_idle got req=%b next=%h v=%b want 0 00003000 0",
                     imem_req, next, instr_valid);
        end
        next_cycle();
        #2;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || next !== 32'h3004) begin
            miscompares++;
            $display("FAIL rw_nopend got req=%b addr=%h next=%h want 1 00003000 00003004",
                     imem_req, imem_addr, next);
        end
        push_exp(32'h3000);
        next_cycle();
        stall = 1'b1;
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rw_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_wrap();
        do_reset();
        pc_force_en = 1'b1;
        pc_force = 32'hFFFF_FFFC;
        next_cycle();
        pc_force_en = 1'b0;
        stall = 1'b0;
        imem_ready = 1'b1;
        #2;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || next !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_top got req=%b addr=%h next=%h want 1 fffffffc 00000000",
                     imem_req, imem_addr, next);
        end
        push_exp(32'hFFFF_FFFC);
        next_cycle();
        #2;
        vectors++;
        if (imem_addr !== 32'h0 || next !== 32'h4) begin
            miscompares++;
            $display("FAIL wrap_zero got addr=%h next=%h want 00000000 00000004", imem_addr, next);
        end
        push_exp(32'h0);
        next_cycle();
        stall = 1'b1;
        next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_drain got %0d pending want 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_wait();
        test_branch();
        test_pending();
        test_jr();
        test_reset_in_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_next_gen.md
# pc_next_gen

Fetch-side sequencer that produces the `next` value fed into the `pc_counter` register and consumes its `current` output. It issues instruction-memory fetches at the current PC, holds the PC through stalls and memory wait states, and applies branch/jump/jr redirects from the decode stage. It delivers each fetched word to the decode stage with a valid strobe. It sits between `pc_counter`, instruction memory and decode.

## Interface
Parameters:
- `RESET_PC`, 32'h00003000: PC value presented on `next` while `reset` is high and in IDLE.

Ports:
- Reset is synchronous, active-high; a single clock domain.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pc_current` in 32: registered PC from `pc_counter.current`.
- `stall` in 1: hazard unit; 1 = no new fetch, PC holds.
- `redirect_valid` in 1: one-cycle redirect request from decode.
- `redirect_kind` in 2: 0 = branch, 1 = jump, 2 = jr; 3 is reserved and ignored.
- `redirect_pc` in 32: PC of the redirecting instruction.
- `branch_imm` in 16: signed word offset.
- `jump_index` in 26: J-type index.
- `jr_target` in 32: register value for jr.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ready` in 1: memory accepts; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched word.
- `next` out 32: next PC, combinational, to `pc_counter.next`.
- `instr_valid` out 1: registered; fetched word is valid.
- `instr_out` out 32: registered fetched word.
- `instr_pc` out 32: registered address of `instr_out`.
- `misalign` out 1: registered one-cycle pulse when a jr target has `[1:0]` not equal to 0.

## Operation
- Target arithmetic:
  - branch = `redirect_pc + 4 + (sext(branch_imm) << 2)`.
  - jump = `{(redirect_pc+4)[31:28], jump_index, 2'b00}`.
  - jr = `{jr_target[31:2], 2'b00}`.
  - All sums are mod 2^32; `pc_current + 4` wraps from 0xFFFFFFFC to 0.
- Pending redirect: a 1-entry register holding a valid bit and a 32-bit target. A new redirect overwrites an unapplied one (latest wins).
- States: IDLE, REQ, WAIT.
  - IDLE: entered on reset and stays for exactly one cycle after `reset` deasserts. `imem_req=0`, `next=RESET_PC`. Goes to REQ.
  - REQ, with a pending or incoming redirect and `stall=0`: `imem_req=0`, `next=target`, pending cleared; stays in REQ. The redirect squashes this cycle's fetch.
  - REQ, `stall=1`: `imem_req=0`, `next=pc_current`. An incoming redirect is captured as pending.
  - REQ, otherwise: `imem_req=1`, `imem_addr=pc_current`.
    - If `imem_ready`: fetch accepted, `next=pc_current+4`.
    - Else: `next=pc_current`, go to WAIT.
  - WAIT: `imem_req=1` with `imem_addr` held at `pc_current`; `next=pc_current`. `stall` is ignored (the request must not be withdrawn). An incoming redirect is captured as pending.
    - On `imem_ready`: fetch accepted, go to REQ. If a redirect is pending, `next=target`, pending cleared, and the word is discarded. Otherwise `next=pc_current+4`.
- Accepted, non-discarded fetch: next cycle `instr_valid=1`, `instr_out=imem_rdata`, `instr_pc=` the fetch address. Otherwise `instr_valid=0`, and `instr_out`/`instr_pc` hold their values.
- A redirect arriving in the same cycle as REQ acceptance wins: `next=target` and the word is discarded.
- `redirect_kind=3` is ignored entirely.
- Reset asserted mid-WAIT: the outstanding fetch is abandoned, pending is cleared, and the next state is IDLE.

## Timing
- Reset values: state=IDLE, `instr_valid=0`, `instr_out=0`, `instr_pc=0`, `misalign=0`, pending=0.
- Combinational outputs while `reset=1`: `imem_req=0`, `next=RESET_PC`, so `pc_counter` loads 0x00003000.
- Zero-wait memory: one fetch per cycle. Word at PC in cycle N; `instr_valid` in N+1; `pc_current=PC+4` in N+1.
- Redirect latency: the redirect cycle squashes that cycle's fetch. `pc_current=target` next cycle; the fetch of target is issued that cycle.
- `misalign` pulses in the cycle after a jr redirect is captured.

## Structure
- Shared `cpu_pkg`:
  - `RESET_PC`.
  - Redirect-kind encodings `RK_BRANCH`, `RK_JUMP`, `RK_JR`.
  - FSM state encoding.
- Sub-module `pc_target_calc`: purely combinational target arithmetic from kind/pc/imm/index/jr.
- FSM, pending register and output registers stay in `pc_next_gen`.

## Test plan
- Reset then free-run with `imem_ready=1`. Required: fetches at 0x3000, 0x3004 and 0x3008 in consecutive cycles, with `instr_pc` trailing by one cycle.
- `imem_ready` low for 3 cycles at 0x3004 with `stall` pulsed meanwhile. Required: `imem_req` and `imem_addr` stay steady, `next` holds 0x3004, exactly one `instr_valid` for 0x3004.
- Branch at `redirect_pc=0x3010`, `imm=0xFFFE`. Required: `next=0x300C`; the fetch in the redirect cycle is squashed.
- Redirects with a pending entry:
  - Jump with `index=0x0000C40`, issued during WAIT: the completing word is discarded, then PC=0x00003100.
  - Two redirects during `stall`: the latest is applied.
- jr `target=0x00003203`. Required: PC=0x00003200 and a single `misalign` pulse.
- Reset asserted in WAIT. Required: next cycle IDLE, `instr_valid=0`, `next=0x00003000`. Also `pc_current=0xFFFFFFFC` free-run wraps to 0x00000000.
